// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone data-memory arbiter.
package wb_arb_pkg;

   // Arbiter FSM states: idle, or granted to master 0 / master 1.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // Default cap on accepted-but-unanswered requests per grant.
   localparam int ARB_DEF_MAX_OUTSTANDING = 4;

   // Width of the outstanding counter for the default cap.
   localparam int ARB_DEF_CNT_W = $clog2(ARB_DEF_MAX_OUTSTANDING + 1);

   // Width needed to count 0..max_out inclusive.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin grant picker: a lone requester wins, and a tie goes
// to the master that was not granted last.
module wb_arb_rr2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // One-hot grant from the request pair and the last-granted pointer.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/wb_dmem_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter for the data memory.
// Grants are held for a whole bus cycle (or lock), and responses are routed
// back to the owning master using an outstanding-request counter.
module wb_dmem_arbiter
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = ARB_DEF_MAX_OUTSTANDING
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   // master 0 (core data port)
   input  logic                m0_cyc_i,
   input  logic                m0_stb_i,
   input  logic                m0_lock_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W/8-1:0] m0_sel_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic                m0_ack_o,
   output logic                m0_err_o,
   output logic                m0_rty_o,
   output logic                m0_stall_o,
   // master 1 (debug / DMA port)
   input  logic                m1_cyc_i,
   input  logic                m1_stb_i,
   input  logic                m1_lock_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W/8-1:0] m1_sel_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                m1_ack_o,
   output logic                m1_err_o,
   output logic                m1_rty_o,
   output logic                m1_stall_o,
   // slave side
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_lock_o,
   output logic                s_we_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W/8-1:0] s_sel_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   input  logic [DATA_W-1:0]   s_rdata_i,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   input  logic                s_rty_i,
   input  logic                s_stall_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

   arb_state_t         r_state;
   logic               r_last;
   logic [CNT_W-1:0]   r_cnt;

   logic [1:0]         w_gnt;
   logic               w_granted;
   logic               w_cyc;
   logic               w_stb;
   logic               w_lock;
   logic               w_we;
   logic [ADDR_W-1:0]  w_addr;
   logic [SEL_W-1:0]   w_sel;
   logic [DATA_W-1:0]  w_wdata;
   logic               w_cap;
   logic               w_accept;
   logic               w_rsp_valid;
   logic               w_fwd;
   logic [CNT_W-1:0]   w_cnt_nxt;

   wb_arb_rr2 u_rr2 (
      .i_req  ({m1_cyc_i, m0_cyc_i}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   assign w_granted = (r_state == GNT0) || (r_state == GNT1);

   // Select the request of the currently granted master.
   always_comb begin
      w_cyc   = 1'b0;
      w_stb   = 1'b0;
      w_lock  = 1'b0;
      w_we    = 1'b0;
      w_addr  = {ADDR_W{1'b0}};
      w_sel   = {SEL_W{1'b0}};
      w_wdata = {DATA_W{1'b0}};
      case (r_state)
         GNT0: begin
            w_cyc   = m0_cyc_i;
            w_stb   = m0_stb_i;
            w_lock  = m0_lock_i;
            w_we    = m0_we_i;
            w_addr  = m0_addr_i;
            w_sel   = m0_sel_i;
            w_wdata = m0_wdata_i;
         end
         GNT1: begin
            w_cyc   = m1_cyc_i;
            w_stb   = m1_stb_i;
            w_lock  = m1_lock_i;
            w_we    = m1_we_i;
            w_addr  = m1_addr_i;
            w_sel   = m1_sel_i;
            w_wdata = m1_wdata_i;
         end
         default: begin
            w_cyc   = 1'b0;
            w_stb   = 1'b0;
         end
      endcase
   end

   // Once the cap is reached, new strobes are held off until a response drains one.
   assign w_cap       = (r_cnt == CNT_MAX);
   assign w_accept    = s_stb_o & ~s_stall_i;
   // Responses with nothing outstanding are stray and dropped.
   assign w_rsp_valid = w_granted & (s_ack_i | s_err_i | s_rty_i) & (r_cnt != CNT_ZERO);
   // A master that already dropped cyc no longer wants its responses.
   assign w_fwd       = w_rsp_valid & w_cyc;

   // Drive the slave request from the granted master, quiet when idle.
   always_comb begin
      s_cyc_o   = w_cyc;
      s_stb_o   = w_stb & ~w_cap;
      s_lock_o  = w_lock;
      s_we_o    = w_we;
      s_addr_o  = w_addr;
      s_sel_o   = w_sel;
      s_wdata_o = w_wdata;
   end

   // Next outstanding count: accept and response in one cycle cancel out.
   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_accept, w_rsp_valid})
         2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
         2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Route stall and responses to the granted master; the other one waits.
   always_comb begin
      m0_stall_o = 1'b1;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_rty_o   = 1'b0;
      m0_rdata_o = {DATA_W{1'b0}};
      m1_stall_o = 1'b1;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_rty_o   = 1'b0;
      m1_rdata_o = {DATA_W{1'b0}};
      case (r_state)
         GNT0: begin
            m0_stall_o = s_stall_i | w_cap;
            m0_ack_o   = w_fwd & s_ack_i;
            m0_err_o   = w_fwd & s_err_i;
            m0_rty_o   = w_fwd & s_rty_i;
            m0_rdata_o = s_rdata_i;
         end
         GNT1: begin
            m1_stall_o = s_stall_i | w_cap;
            m1_ack_o   = w_fwd & s_ack_i;
            m1_err_o   = w_fwd & s_err_i;
            m1_rty_o   = w_fwd & s_rty_i;
            m1_rdata_o = s_rdata_i;
         end
         default: begin
            m0_stall_o = 1'b1;
            m1_stall_o = 1'b1;
         end
      endcase
   end

   // Arbitration FSM, last-granted pointer and outstanding counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_cnt <= w_cnt_nxt;
         case (r_state)
            IDLE: begin
               if (w_gnt[0]) begin
                  r_state <= GNT0;
                  r_last  <= 1'b0;
               end else if (w_gnt[1]) begin
                  r_state <= GNT1;
                  r_last  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_last  <= r_last;
               end
            end
            GNT0, GNT1: begin
               // Release only when cyc and lock are gone and nothing is in flight.
               if (!w_cyc && !w_lock && (w_cnt_nxt == CNT_ZERO)) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= r_state;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_dmem_arbiter.md
Name: wb_dmem_arbiter

Overview:
Two-master to one-slave arbiter for the pipelined Wishbone data-memory port. Master 0 is the core data port (dmem_wb); master 1 is a secondary master such as a debug/DMA port. It sits between yarc_platform and sp_mem_wb, so either master can reach dmem without changing the core. It arbitrates round-robin, holds a grant for a whole bus cycle, and tracks outstanding pipelined requests so responses return to the correct master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (sel width = DATA_W/8)
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests per grant (>=1)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m0_cyc_i, m1_cyc_i  in  1 each  master cycle request
m0_stb_i, m1_stb_i  in  1 each  master strobe
m0_lock_i, m1_lock_i  in  1 each  master bus lock
m0_we_i, m1_we_i  in  1 each  write enable
m0_addr_i, m1_addr_i  in  ADDR_W each  byte address
m0_sel_i, m1_sel_i  in  DATA_W/8 each  byte selects
m0_wdata_i, m1_wdata_i  in  DATA_W each  write data
m0_rdata_o, m1_rdata_o  out  DATA_W each  read data
m0_ack_o, m1_ack_o  out  1 each  ack
m0_err_o, m1_err_o  out  1 each  error
m0_rty_o, m1_rty_o  out  1 each  retry
m0_stall_o, m1_stall_o  out  1 each  stall
s_cyc_o, s_stb_o, s_lock_o, s_we_o  out  1 each  to slave
s_addr_o  out  ADDR_W  to slave
s_sel_o  out  DATA_W/8  to slave
s_wdata_o  out  DATA_W  to slave
s_rdata_i  in  DATA_W  from slave
s_ack_i, s_err_i, s_rty_i, s_stall_i  in  1 each  from slave

Behaviour:
- FSM states: IDLE, GNT0, GNT1. The FSM and the last-granted pointer (last_q) are registered.
- Reset (async, rstn_i=0): state=IDLE, last_q=1 (master 0 wins the first tie), outstanding=0. Slave cyc/stb/lock=0. Master ack/err/rty=0, master stall=1, rdata=0.
- IDLE:
  - Neither cyc asserted -> stay in IDLE.
  - One cyc asserted -> grant to that master next cycle.
  - Both asserted -> grant to the master != last_q, and last_q is updated.
  - In IDLE both stalls are 1 and s_cyc_o=0. Arbitration latency is 1 cycle.
- GNTx forwarding: the slave request signals (cyc, stb, lock, we, addr, sel, wdata) mirror master x combinationally.
- GNTx stall routing:
  - mx_stall_o = s_stall_i | (outstanding==MAX_OUTSTANDING).
  - While the cap is reached, s_stb_o is forced to 0.
  - The non-granted master always sees stall=1 and ack/err/rty=0.
- Accept = s_stb_o & ~s_stall_i. Response = s_ack_i | s_err_i | s_rty_i.
- Outstanding counter:
  - +1 on accept only; -1 on response only; unchanged when both occur in the same cycle.
  - A response with outstanding==0 is dropped (not forwarded) and the counter stays at 0.
- Response routing: s_rdata_i, ack, err and rty go combinationally to the granted master only. Master rdata is 0 when that master is not granted.
- Grant release: GNTx -> IDLE when mx_cyc_i==0 and mx_lock_i==0 and outstanding==0 (counting a response in that same cycle).
  - While lock is held, cyc may drop between cycles and the grant is kept.
- A master dropping cyc with responses still outstanding is a protocol violation. The grant is held until the counter drains, and those responses are discarded.
- No direct GNT0->GNT1 transition. The FSM always passes through IDLE, which gives fair alternation under continuous contention.
- Reset asserted mid-transaction: everything returns to reset values immediately and in-flight slave responses are lost.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum arb_state_t {IDLE, GNT0, GNT1}
  - localparam for the counter width, $clog2(MAX_OUTSTANDING+1)
- Natural sub-module: wb_arb_rr2, a 2-way round-robin grant picker (requests, last_q in; grant one-hot out).
- The outstanding counter and the muxing stay in the top module.

Test Plan:
- Single master 0: m0 issues 3 back-to-back reads (addr 0x0, 0x4, 0x8) -> m0_stall_o=1 for 1 cycle after cyc rises, then 3 accepts and 3 acks forwarded. m1_ack_o stays 0. Grant returns to IDLE once cyc drops and outstanding=0.
- Contention: m0 and m1 assert cyc in the same cycle after reset -> m0 granted first. After m0 finishes, m1 is granted; a repeated tie then goes to m0. The grant sequence is 0,1,0.
- Outstanding cap (MAX_OUTSTANDING=2, slave acks delayed 5 cycles): m1 issues 4 stbs -> the 3rd stb is stalled until the first ack arrives and s_stb_o never exceeds 2 unacked. All 4 acks reach m1.
- Lock hold: m0 asserts lock and does a write then drops cyc for 2 cycles; m1 requests meanwhile -> m1 stays stalled until m0 drops lock. m1 is then granted after 1 IDLE cycle.
- Simultaneous accept + ack with outstanding=1 -> the counter stays 1. A spurious s_ack_i while IDLE is not forwarded to either master.
- Reset mid-burst: rstn_i low while m0 has 2 outstanding -> stalls=1, s_cyc_o=0 and acks=0 asynchronously. After release, a fresh m1 request is granted normally.
